sha3_digest_axis_out: RTL and testbench

// - Output stage of the SHA3 datapath: takes the 5x5x64 Keccak state after the final permutation and truncates it to the

---
 rtl/sha3_pkg.sv | 25 ++
 rtl/sha3_digest_axis_out.sv | 107 ++++++++++
 tb/tb_sha3_digest_axis_out.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sha3_pkg.sv
// Shared SHA3 types and digest-length helpers used by the loader, round core and output stage.
package sha3_pkg;

  localparam int unsigned MAX_DIGEST = 512;
  localparam int unsigned CNT_W      = 6;

  typedef logic [4:0][4:0][63:0] keccak_state_t;

  typedef enum logic [1:0] {SHA3_224, SHA3_256, SHA3_384, SHA3_512} sha3_mode_t;

  // Digest length in bits; anything unrecognised falls back to SHA3-256.
  function automatic int unsigned digest_bits(sha3_mode_t mode);
    case (mode)
      SHA3_224: return 224;
      SHA3_384: return 384;
      SHA3_512: return 512;
      default:  return 256;
    endcase
  endfunction

  function automatic int unsigned beat_count(sha3_mode_t mode, int unsigned dw);
    return (digest_bits(mode) + dw - 1) / dw;
  endfunction

endpackage

// File: rtl/sha3_digest_axis_out.sv
// SHA3 output stage: truncates the final Keccak state to the selected digest length
// and streams it least-significant beat first as an AXI-Stream master.
module sha3_digest_axis_out
  import sha3_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  keccak_state_t         state_in,
  input  logic                  state_valid,
  input  logic [1:0]            state_tid,
  output logic                  state_ready,
  output logic                  M_TVALID,
  input  logic                  M_TREADY,
  output logic [DATA_WIDTH-1:0] M_TDATA,
  output logic                  M_TLAST,
  output logic [1:0]            M_TID,
  output logic                  digest_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int unsigned FLAT_W = 1600;

  logic [1:0]            state;
  logic [1:0]            state_n;
  logic [MAX_DIGEST-1:0] shreg;
  logic [MAX_DIGEST-1:0] shreg_n;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_n;
  logic [1:0]            tid_n;
  logic [FLAT_W-1:0]     flat;
  logic [MAX_DIGEST-1:0] mask;
  logic                  unused_upper;
  sha3_mode_t            mode;

  // Packed state order already matches lane index 5x+y, so the flat view is a plain reinterpretation.
  assign flat         = FLAT_W'(state_in);
  assign unused_upper = ^flat[FLAT_W-1:MAX_DIGEST];
  assign mode         = sha3_mode_t'(state_tid);
  assign mask         = {MAX_DIGEST{1'b1}} >> (MAX_DIGEST - digest_bits(mode));

  assign M_TDATA = shreg[DATA_WIDTH-1:0];

  // Next-state and datapath update; in SEND the registered M_TVALID is always high.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    tid_n   = M_TID;
    case (state)
      IDLE: begin
        if (state_valid) begin
          shreg_n = flat[MAX_DIGEST-1:0] & mask;
          cnt_n   = CNT_W'(beat_count(mode, DATA_WIDTH) - 1);
          tid_n   = state_tid;
          state_n = SEND;
        end
      end
      SEND: begin
        if (M_TREADY) begin
          shreg_n = shreg >> DATA_WIDTH;
          if (cnt == '0) begin
            state_n = DONE;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      shreg       <= '0;
      cnt         <= '0;
      M_TID       <= '0;
      state_ready <= 1'b1;
      M_TVALID    <= 1'b0;
      M_TLAST     <= 1'b0;
      digest_done <= 1'b0;
    end else begin
      shreg       <= shreg_n;
      cnt         <= cnt_n;
      M_TID       <= tid_n;
      state_ready <= (state_n == IDLE);
      M_TVALID    <= (state_n == SEND);
      M_TLAST     <= (state_n == SEND) && (cnt_n == '0);
      digest_done <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_sha3_digest_axis_out.sv
// Directed bench for sha3_digest_axis_out at DATA_WIDTH 16 and 64.
module tb_sha3_digest_axis_out;
  import sha3_pkg::*;

  logic          clk;
  logic          rst_n;
  keccak_state_t state_in;
  logic [1:0]    tid;
  logic          valid16, valid64, tready;
  logic          ready16, tv16, tl16, dn16;
  logic          ready64, tv64, tl64, dn64;
  logic [15:0]   td16;
  logic [63:0]   td64;
  logic [1:0]    ti16, ti64;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int unsigned last_hs_cyc = 0;
  int unsigned first_v_cyc = 0;

  logic [63:0] got_data[$];
  logic        got_last[$];
  logic [63:0] exp_data[$];

  sha3_digest_axis_out #(.DATA_WIDTH(16)) dut16 (
    .ACLK(clk), .ARESETn(rst_n), .state_in(state_in), .state_valid(valid16), .state_tid(tid),
    .state_ready(ready16), .M_TVALID(tv16), .M_TREADY(tready), .M_TDATA(td16), .M_TLAST(tl16),
    .M_TID(ti16), .digest_done(dn16)
  );

  sha3_digest_axis_out #(.DATA_WIDTH(64)) dut64 (
    .ACLK(clk), .ARESETn(rst_n), .state_in(state_in), .state_valid(valid64), .state_tid(tid),
    .state_ready(ready64), .M_TVALID(tv64), .M_TREADY(tready), .M_TDATA(td64), .M_TLAST(tl64),
    .M_TID(ti64), .digest_done(dn64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Lane k = 5x+y holds four 16-bit words 4k..4k+3, so 16-bit beat i carries the value i.
  function automatic keccak_state_t ramp_state();
    keccak_state_t s;
    for (int k = 0; k < 25; k++) begin
      s[k/5][k%5] = {16'(4*k+3), 16'(4*k+2), 16'(4*k+1), 16'(4*k)};
    end
    return s;
  endfunction

  task automatic expect_ramp(input int n);
    exp_data.delete();
    for (int i = 0; i < n; i++) exp_data.push_back(64'(i));
  endtask

  task automatic send(input bit use64, input keccak_state_t s, input logic [1:0] t);
    @(posedge clk); #1;
    state_in = s;
    tid      = t;
    if (use64) valid64 = 1'b1;
    else       valid16 = 1'b1;
    @(posedge clk); #1;
    valid16 = 1'b0;
    valid64 = 1'b0;
  endtask

  // Accepts beats until digest_done; checks hold-while-stalled, TID, and done timing along the way.
  task automatic collect(input bit use64, input bit rand_ready, input int inject_at,
                         input logic [1:0] exp_tid);
    bit          done_seen = 1'b0;
    bit          stalled   = 1'b0;
    bit          first     = 1'b1;
    logic [63:0] hold_d    = '0;
    logic        hold_l    = 1'b0;
    logic        v, l, dn, rdy;
    logic [63:0] d;
    logic [1:0]  t;
    got_data.delete();
    got_last.delete();
    for (int c = 0; c < 400 && !done_seen; c++) begin
      tready  = rand_ready ? 1'($urandom_range(1)) : 1'b1;
      valid16 = (c == inject_at);
      if (c == inject_at) begin
        state_in = '1;
        tid      = 2'd2;
      end
      @(negedge clk);
      v   = use64 ? tv64 : tv16;
      l   = use64 ? tl64 : tl16;
      dn  = use64 ? dn64 : dn16;
      rdy = use64 ? ready64 : ready16;
      d   = use64 ? td64 : 64'(td16);
      t   = use64 ? ti64 : ti16;
      if (c == 0) check("first_valid", 64'(v), 64'd1);
      if (first && v) begin
        first_v_cyc = cyc;
        first       = 1'b0;
      end
      if (stalled) begin
        check("hold_valid", 64'(v), 64'd1);
        check("hold_data", d, hold_d);
        check("hold_last", 64'(l), 64'(hold_l));
      end
      if (v) check("tid", 64'(t), 64'(exp_tid));
      stalled = v && !tready;
      hold_d  = d;
      hold_l  = l;
      if (v && tready) begin
        got_data.push_back(d);
        got_last.push_back(l);
        if (l) last_hs_cyc = cyc;
      end
      if (dn) begin
        done_seen = 1'b1;
        check("done_latency", 64'(cyc - last_hs_cyc), 64'd1);
        check("ready_in_done", 64'(rdy), 64'd0);
      end
      if (!done_seen) begin
        @(posedge clk); #1;
      end
    end
    valid16 = 1'b0;
    tready  = 1'b1;
    check("done_seen", 64'(done_seen), 64'd1);
  endtask

  task automatic compare_packet(input string name);
    int n;
    n = exp_data.size();
    check({name, "_beats"}, 64'(got_data.size()), 64'(n));
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      check($sformatf("%s_data%0d", name, i), got_data[i], exp_data[i]);
      check($sformatf("%s_last%0d", name, i), 64'(got_last[i]), 64'(i == n - 1));
    end
  endtask

  initial begin
    keccak_state_t s;
    int unsigned   p1_last;
    int            extra;

    rst_n    = 1'b1;
    valid16  = 1'b0;
    valid64  = 1'b0;
    tready   = 1'b1;
    state_in = '0;
    tid      = 2'd0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_ready16", 64'(ready16), 64'd1);
    check("rst_valid16", 64'(tv16), 64'd0);
    check("rst_last16",  64'(tl16), 64'd0);
    check("rst_data16",  64'(td16), 64'd0);
    check("rst_tid16",   64'(ti16), 64'd0);
    check("rst_done16",  64'(dn16), 64'd0);
    check("rst_ready64", 64'(ready64), 64'd1);
    check("rst_valid64", 64'(tv64), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // SHA3-256 at 16 bits: one nonzero lane, then zero padding up to 256 bits.
    s       = '0;
    s[0][0] = 64'h0123_4567_89AB_CDEF;
    send(1'b0, s, 2'd1);
    collect(1'b0, 1'b0, -1, 2'd1);
    exp_data.delete();
    exp_data.push_back(64'hCDEF);
    exp_data.push_back(64'h89AB);
    exp_data.push_back(64'h4567);
    exp_data.push_back(64'h0123);
    for (int i = 0; i < 12; i++) exp_data.push_back(64'h0);
    compare_packet("t256");

    // SHA3-224 at 64 bits: the top half of the last beat lies beyond 224 and must be cleared.
    send(1'b1, '1, 2'd0);
    collect(1'b1, 1'b0, -1, 2'd0);
    exp_data.delete();
    for (int i = 0; i < 3; i++) exp_data.push_back('1);
    exp_data.push_back(64'h0000_0000_FFFF_FFFF);
    compare_packet("t224w64");

    // SHA3-512 with random backpressure.
    send(1'b0, ramp_state(), 2'd3);
    collect(1'b0, 1'b1, -1, 2'd3);
    expect_ramp(32);
    compare_packet("t512rnd");

    // A second state offered mid-packet must be ignored entirely.
    send(1'b0, ramp_state(), 2'd1);
    collect(1'b0, 1'b0, 3, 2'd1);
    expect_ramp(16);
    compare_packet("tinject");
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tv16) extra++;
    end
    check("no_second_pkt", 64'(extra), 64'd0);

    // Reset while beat 5 of a SHA3-384 packet is on the bus.
    send(1'b0, ramp_state(), 2'd2);
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("pre_rst_data", 64'(td16), 64'd5);
    check("pre_rst_last", 64'(tl16), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(tv16), 64'd0);
    check("mid_rst_data",  64'(td16), 64'd0);
    check("mid_rst_tid",   64'(ti16), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 64'(ready16), 64'd1);
    check("post_rst_valid", 64'(tv16), 64'd0);
    send(1'b0, ramp_state(), 2'd2);
    collect(1'b0, 1'b0, -1, 2'd2);
    expect_ramp(24);
    compare_packet("t384");

    // Back-to-back packets at the earliest possible capture.
    send(1'b0, ramp_state(), 2'd1);
    collect(1'b0, 1'b0, -1, 2'd1);
    expect_ramp(16);
    compare_packet("b2b_a");
    p1_last = last_hs_cyc;
    send(1'b0, ramp_state(), 2'd3);
    collect(1'b0, 1'b0, -1, 2'd3);
    expect_ramp(32);
    compare_packet("b2b_b");
    check("b2b_gap", 64'(first_v_cyc - p1_last), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
